// File: rtl/d_grf_read_ctrl_pkg.sv
// rtl/d_grf_read_ctrl_pkg.sv - widths and Tnew/Tuse encodings for the D-stage GRF read controller
package d_grf_read_ctrl_pkg;

  localparam int TW = 2;
  localparam int OW = 2;

  localparam logic [TW-1:0] TNEW_ALU    = TW'(1);
  localparam logic [TW-1:0] TNEW_LOAD   = TW'(2);
  localparam logic [TW-1:0] TNEW_MDU_MF = TW'(1);

  localparam logic [TW-1:0] TUSE_BRANCH = TW'(0);
  localparam logic [TW-1:0] TUSE_ALU    = TW'(1);
  localparam logic [TW-1:0] TUSE_STORE  = TW'(2);

  function automatic logic [TW-1:0] tn_dec_sat(input logic [TW-1:0] v);
    return (v == '0) ? '0 : v - TW'(1);
  endfunction

endpackage

// File: rtl/grf_sb_entry.sv
// rtl/grf_sb_entry.sv - one register's scoreboard entry: outstanding-write count and remaining Tnew
module grf_sb_entry
  import d_grf_read_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          iss_hit,
  input  logic          cm_hit,
  input  logic [TW-1:0] tnew,
  output logic [OW-1:0] out,
  output logic [TW-1:0] tn
);

  localparam logic [OW-1:0] OUT_MAX = {OW{1'b1}};

  logic          cm_eff;
  logic [OW-1:0] out_nx;
  logic [TW-1:0] tn_nx;

  // A commit with nothing in flight is spurious and must not disturb the entry.
  assign cm_eff = cm_hit && (out != '0);

  always_comb begin
    out_nx = out;
    if (iss_hit && !cm_eff) begin
      if (out != OUT_MAX) out_nx = out + OW'(1);
    end else if (cm_eff && !iss_hit) begin
      out_nx = out - OW'(1);
    end

    tn_nx = iss_hit ? tnew : tn_dec_sat(tn);
    if (out_nx == '0) tn_nx = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
      tn  <= '0;
    end else begin
      out <= out_nx;
      tn  <= tn_nx;
    end
  end

endmodule

// File: rtl/d_grf_read_ctrl.sv
// rtl/d_grf_read_ctrl.sv - D-stage operand bypass from the W-stage write port and Tuse/Tnew stall scoreboard
module d_grf_read_ctrl
  import d_grf_read_ctrl_pkg::*;
(
  input  logic          Clk,
  input  logic          Reset,
  input  logic [4:0]    A1,
  input  logic [4:0]    A2,
  input  logic [TW-1:0] Tuse1,
  input  logic [TW-1:0] Tuse2,
  input  logic [31:0]   Read1,
  input  logic [31:0]   Read2,
  input  logic          issue_valid,
  input  logic [4:0]    issue_wa,
  input  logic [TW-1:0] issue_tnew,
  input  logic          WE,
  input  logic [4:0]    WA,
  input  logic [31:0]   WD,
  output logic [31:0]   RD1,
  output logic [31:0]   RD2,
  output logic          stall,
  output logic          ovf
);

  localparam logic [OW-1:0] OUT_MAX = {OW{1'b1}};

  logic [OW-1:0] out_q [32];
  logic [TW-1:0] tn_q  [32];
  logic          iss;
  logic          cm;
  logic          hz1;
  logic          hz2;

  assign out_q[0] = '0;
  assign tn_q[0]  = '0;

  assign cm  = WE && (WA != 5'd0);
  assign iss = issue_valid && !stall && (issue_wa != 5'd0);

  for (genvar r = 1; r < 32; r++) begin : g_sb
    grf_sb_entry u_entry (
      .clk     (Clk),
      .rst_n   (Reset),
      .iss_hit (iss && (issue_wa == 5'(r))),
      .cm_hit  (cm && (WA == 5'(r))),
      .tnew    (issue_tnew),
      .out     (out_q[r]),
      .tn      (tn_q[r])
    );
  end

  // Hazard uses pre-edge scoreboard state; a same-cycle commit is covered by the bypass.
  assign hz1   = (A1 != 5'd0) && (out_q[A1] != '0) && (tn_q[A1] > Tuse1);
  assign hz2   = (A2 != 5'd0) && (out_q[A2] != '0) && (tn_q[A2] > Tuse2);
  assign stall = hz1 | hz2;

  assign RD1 = (A1 == 5'd0) ? 32'd0 : (cm && (WA == A1)) ? WD : Read1;
  assign RD2 = (A2 == 5'd0) ? 32'd0 : (cm && (WA == A2)) ? WD : Read2;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ovf <= 1'b0;
    end else if (iss && (out_q[issue_wa] == OUT_MAX) && !(cm && (WA == issue_wa))) begin
      ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_d_grf_read_ctrl.sv
// tb/tb_d_grf_read_ctrl.sv - directed self-checking bench for d_grf_read_ctrl
module tb_d_grf_read_ctrl;
  import d_grf_read_ctrl_pkg::*;

  logic          Clk = 1'b0;
  logic          Reset;
  logic [4:0]    A1, A2;
  logic [TW-1:0] Tuse1, Tuse2;
  logic [31:0]   Read1, Read2;
  logic          issue_valid;
  logic [4:0]    issue_wa;
  logic [TW-1:0] issue_tnew;
  logic          WE;
  logic [4:0]    WA;
  logic [31:0]   WD;
  logic [31:0]   RD1, RD2;
  logic          stall, ovf;

  int n_cmp = 0;
  int n_err = 0;

  d_grf_read_ctrl dut (
    .Clk(Clk), .Reset(Reset), .A1(A1), .A2(A2), .Tuse1(Tuse1), .Tuse2(Tuse2),
    .Read1(Read1), .Read2(Read2), .issue_valid(issue_valid), .issue_wa(issue_wa),
    .issue_tnew(issue_tnew), .WE(WE), .WA(WA), .WD(WD),
    .RD1(RD1), .RD2(RD2), .stall(stall), .ovf(ovf)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    WE          = 1'b0;
  endtask

  task automatic issue(input logic [4:0] wa, input logic [TW-1:0] tnew);
    issue_valid = 1'b1;
    issue_wa    = wa;
    issue_tnew  = tnew;
  endtask

  initial begin
    Reset = 1'b0;
    A1 = '0; A2 = '0; Tuse1 = '0; Tuse2 = '0;
    Read1 = 32'h55; Read2 = 32'h11;
    issue_valid = 1'b0; issue_wa = '0; issue_tnew = '0;
    WE = 1'b0; WA = '0; WD = '0;
    #12;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_rd1_a0", RD1, 32'd0);
    Reset = 1'b1;
    step();

    // 1: async reset clears a register with two writes in flight
    issue(5'd5, 2'd3); step();
    issue(5'd5, 2'd3); step();
    idle(); A1 = 5'd5; Tuse1 = 2'd0; #1;
    chk("t1_stall_before", 32'(stall), 32'd1);
    Reset = 1'b0; #1;
    chk("t1_stall_async", 32'(stall), 32'd0);
    chk("t1_ovf_async", 32'(ovf), 32'd0);
    Reset = 1'b1;
    step();
    chk("t1_stall_after", 32'(stall), 32'd0);

    // 2: load-use stall of two cycles, none when Tuse covers Tnew
    A1 = 5'd0;
    issue(5'd8, TNEW_LOAD); step();
    idle(); A1 = 5'd8; Tuse1 = TUSE_BRANCH; #1;
    chk("t2_stall_c1", 32'(stall), 32'd1);
    step();
    chk("t2_stall_c2", 32'(stall), 32'd1);
    step();
    chk("t2_stall_c3", 32'(stall), 32'd0);
    Tuse1 = TUSE_STORE;
    issue(5'd8, TNEW_LOAD); step();
    idle(); #1;
    chk("t2_tuse2_a", 32'(stall), 32'd0);
    step();
    chk("t2_tuse2_b", 32'(stall), 32'd0);

    // 3: bypass muxes
    A1 = 5'd0; Tuse1 = '0;
    WE = 1'b1; WA = 5'd3; WD = 32'hDEADBEEF; A2 = 5'd3; Read2 = 32'h11; #1;
    chk("t3_rd2_bypass", RD2, 32'hDEADBEEF);
    chk("t3_rd1_zero", RD1, 32'd0);
    WA = 5'd0; #1;
    chk("t3_rd2_wa0", RD2, 32'h11);
    WA = 5'd3; A1 = 5'd7; Read1 = 32'h1234; #1;
    chk("t3_rd1_nomatch", RD1, 32'h1234);
    WE = 1'b0; #1;
    chk("t3_rd2_we0", RD2, 32'h11);
    A2 = 5'd0; A1 = 5'd0;

    // 4: two writes in flight to r9; first commit leaves it tracked
    issue(5'd9, 2'd3); step();
    issue(5'd9, 2'd3); step();
    idle(); A1 = 5'd9; Tuse1 = 2'd0; WE = 1'b1; WA = 5'd9; WD = 32'hCAFE0009; #1;
    chk("t4_stall_pre", 32'(stall), 32'd1);
    chk("t4_rd1_bypass", RD1, 32'hCAFE0009);
    step();
    chk("t4_stall_out1", 32'(stall), 32'd1);
    step();
    WE = 1'b0; #1;
    chk("t4_stall_out0", 32'(stall), 32'd0);
    A1 = 5'd0;

    // 5: issue and commit to r12 in the same cycle
    issue(5'd12, 2'd1); step();
    issue(5'd12, 2'd3); WE = 1'b1; WA = 5'd12; step();
    idle(); A1 = 5'd12; Tuse1 = 2'd2; #1;
    chk("t5_stall_tn3_tuse2", 32'(stall), 32'd1);
    Tuse1 = 2'd3; #1;
    chk("t5_stall_tn3_tuse3", 32'(stall), 32'd0);
    Tuse1 = 2'd0;
    step();
    chk("t5_stall_tn2", 32'(stall), 32'd1);
    WE = 1'b1; WA = 5'd12; step();
    WE = 1'b0; #1;
    chk("t5_stall_cleared", 32'(stall), 32'd0);
    A1 = 5'd0;

    // 6: saturation, sticky ovf, issue under stall ignored
    issue(5'd4, 2'd0); step();
    issue(5'd4, 2'd0); step();
    issue(5'd4, 2'd0); step();
    chk("t6_ovf_at3", 32'(ovf), 32'd0);
    issue(5'd4, 2'd3); step();
    chk("t6_ovf_set", 32'(ovf), 32'd1);
    idle(); A1 = 5'd4; Tuse1 = 2'd0; #1;
    chk("t6_stall_sat", 32'(stall), 32'd1);
    issue(5'd20, 2'd3); step();
    idle(); #1;
    chk("t6_ovf_sticky1", 32'(ovf), 32'd1);
    A1 = 5'd20; #1;
    chk("t6_ignored_issue", 32'(stall), 32'd0);
    step(); step();
    chk("t6_ovf_sticky2", 32'(ovf), 32'd1);
    Reset = 1'b0; #1;
    chk("t6_ovf_reset", 32'(ovf), 32'd0);
    Reset = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/d_grf_read_ctrl.md
Name: d_grf_read_ctrl

Overview:
- D-stage read side of the GRF write interface.
- Consumes the W-stage write port (WE/WA/WD) and the raw GRF read data, and returns bypassed operands.
- Keeps a per-register scoreboard of in-flight writes and raises a stall when an operand's producer cannot deliver by its consumer's Tuse.
- Sits between the D-stage decoder, the GRF and the pipeline stall logic.

Parameters:
- TW, 2: width of Tnew/Tuse counters; maximum value 3.
- OW, 2: width of the per-register outstanding-write counter; maximum 3 writes in flight across E/M/W.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset; Reset=0 clears all state immediately.
- A1  input  5  D-stage source register 1.
- A2  input  5  D-stage source register 2.
- Tuse1  input  TW  cycles until A1's value is consumed.
- Tuse2  input  TW  cycles until A2's value is consumed.
- Read1  input  32  raw GRF data for A1.
- Read2  input  32  raw GRF data for A2.
- issue_valid  input  1  D-stage instruction that writes a register is leaving D this cycle.
- issue_wa  input  5  destination of the issuing instruction.
- issue_tnew  input  TW  cycles from E entry until that result is forwardable.
- WE  input  1  W-stage write enable; same cycle the GRF is written.
- WA  input  5  W-stage write address.
- WD  input  32  W-stage write data.
- RD1  output  32  bypassed operand 1.
- RD2  output  32  bypassed operand 2.
- stall  output  1  freeze F/D and bubble E.
- ovf  output  1  sticky error: an issue was attempted with the outstanding count already at 3.

Behaviour:
- State per register r (1..31):
  - out[r], OW bits: count of in-flight writes.
  - tn[r], TW bits: remaining Tnew of the youngest in-flight write.
  - r=0 is never tracked; its state is constant zero.
- Reset (Reset=0, asynchronous):
  - all out, tn and ovf cleared.
  - stall=0.
  - RD1/RD2 follow the combinational rules below, i.e. raw GRF data when no bypass applies.
- RD1/RD2 are combinational, zero latency:
  - RD1 = WD if (WE && WA!=0 && WA==A1), else Read1.
  - RD2 uses the same rule with A2.
  - A1=0 or A2=0 always yields 0.
- stall is combinational:
  - hz1 = A1!=0 && out[A1]!=0 && tn[A1]>Tuse1.
  - hz2 is the same rule with A2/Tuse2.
  - stall = hz1 | hz2.
- Effective issue:
  - iss = issue_valid && !stall && issue_wa!=0.
  - Issue while stall=1 is ignored; the stage logic must not present it.
- Commit:
  - cm = WE && WA!=0.
  - cm must correspond to an earlier issue; a commit with out[WA]==0 leaves state unchanged.
- Per rising edge, for each r:
  - tn[r] decrements, saturating at 0, every cycle regardless of stall, since E/M/W always advance.
  - iss && r==issue_wa: tn[r] is loaded with issue_tnew. The load wins over the decrement.
  - out[r] update:
    - +1 on iss only.
    - -1 on cm only.
    - unchanged when iss and cm both hit r in the same cycle.
    - when out[r] reaches 0, tn[r] is forced to 0.
  - iss with out[issue_wa]==3 and no matching cm: out holds at 3 and ovf is set. ovf clears only on reset.
- Same-cycle read/commit to one register: RD uses WD via the bypass, and the hazard check uses the pre-edge state (out, tn).
- A stall lasts until the condition tn[A]<=Tuse holds. No timeout.

Decomposition:
- Shared package/header:
  - TW/OW widths.
  - Tnew encodings for ALU=1, load=2, MDU-mf=1.
  - Tuse encodings for branch/jr=0, ALU=1, store-data=2.
- One natural sub-module: grf_sb_entry, holding one register's out/tn counters with inc/dec/load/saturation logic, instantiated 31 times.
- Bypass muxes and stall OR stay in the top module.

Test Plan:
1. Reset=0 mid-run with out[5]=2 -> out/tn/ovf cleared immediately; stall=0 while A1=5, Tuse1=0.
2. Issue wa=8, tnew=2 (load); next cycle A1=8, Tuse1=0 -> stall=1 for 2 cycles, then 0 once tn reaches 0. A1=8, Tuse1=2 -> never stalls.
3. WE=1, WA=3, WD=0xDEADBEEF, A2=3, Read2=0x11 -> RD2=0xDEADBEEF. Same with WA=0 -> RD2=Read2. A1=0 -> RD1=0.
4. Issue wa=9, tnew=2, then issue wa=9, tnew=1 one cycle later -> out[9]=2, tn[9]=1. The first commit leaves out=1, still tracked. The second commit gives out=0 and stall clears.
5. Issue and commit to r=12 in the same cycle with out[12]=1 -> out stays 1 and tn is loaded with the new tnew.
6. Four issues to r=4 with no commits -> out saturates at 3 and ovf=1 sticky until Reset=0. Issue with stall=1 -> state unchanged.
